deserializador_6bit: RTL and testbench
======================================

// Module: deserializador_6bit
// PURPOSE
//  Upstream feeder of the 22-number 6-bit comparator. Receives framed serial words,
//  assembles each 6-bit word and holds it on Palabra with a valid/ready handshake.
//  Palabra drives the comparator's Entrada[5:0] directly.
// PARAMETERS
//  ANCHO          6  data bits per frame; the comparator requires 6
//  PARIDAD_IMPAR  0  0 = even parity, 1 = odd; used only with DESERIALIZADOR_PARIDAD_EN
// PORTS
//  Reloj       in   1      single clock, rising edge
//  nReset      in   1      reset, asynchronous, active-low
//  DatoSerie   in   1      serial line, idle high
//  Muestra     in   1      one-cycle strobe, one per bit period, at mid-bit
//  Listo       in   1      downstream accepts Palabra when Valido & Listo
//  Palabra     out  ANCHO  assembled word, LSB received first
//  Valido      out  1      Palabra holds an unconsumed word
//  ErrorTrama  out  1      one-cycle pulse: bad stop bit (or bad parity)
//  Desborde    out  1      one-cycle pulse: frame completed while Valido & ~Listo
// BEHAVIOUR
//  - Reset: all outputs 0, FSM = REPOSO, bit counter 0. Async assert, sync release.
//  - Line and control are sampled only on cycles with Muestra=1. Otherwise the FSM holds.
//  - FSM states:
//    REPOSO:  DatoSerie=0 on a strobe -> DATOS (start bit). Counter is cleared.
//    DATOS:   shift DatoSerie into the MSB of the shift register (LSB-first frame).
//             After ANCHO strobes -> PARIDAD if the macro is defined, else PARADA.
//    PARIDAD: compare the received bit with the XOR of the data (^PARIDAD_IMPAR)
//             -> PARADA. A mismatch is recorded in an error flag.
//    PARADA:  DatoSerie=1 and no error -> deliver, then REPOSO.
//             DatoSerie=0 or error flag set -> ErrorTrama=1 for one cycle, word discarded, REPOSO.
//  - Deliver:
//    Valido=0, or (Valido & Listo) in the same cycle -> Palabra <= shift reg, Valido=1.
//    Otherwise -> Desborde=1 for one cycle; old Palabra and Valido are kept; new word dropped.
//  - Handshake: Valido & Listo with no delivery that cycle -> Valido=0 next cycle.
//    Palabra is stable while Valido=1. Listo may be high while Valido=0 (no effect).
//  - Latency: Valido rises 1 cycle after the stop-bit strobe.
//  - Back-to-back frames are accepted: a start bit on the strobe right after the
//    stop-bit strobe is detected.
//  - Muestra high on consecutive cycles: each cycle counts as a bit.
//  - nReset mid-frame aborts the frame immediately, with no error pulse.
//  - ErrorTrama and Desborde never assert in the same cycle.
// CONFIGURATION
//  DESERIALIZADOR_PARIDAD_EN defined:
//    frame = start + ANCHO data + parity + stop; parity is checked as above.
//  Not defined:
//    frame = start + ANCHO data + stop; PARIDAD state and error flag are not built.
//    PARIDAD_IMPAR is ignored.
// STRUCTURE
//  Package paq_deserializador holds:
//    state typedef {REPOSO, DATOS, PARIDAD, PARADA};
//    ANCHO_CONT = $clog2(ANCHO+1);
//    constants LINEA_REPOSO=1'b1, BIT_INICIO=1'b0.
//  Natural sub-module: registro_salida_vr, the Palabra/Valido holding register
//  with overrun detection. FSM and shift register stay in the top module.
// TESTING
//  1. Frame 0,101001(LSB first),1 -> Palabra=6'h25, Valido=1 one cycle after the stop strobe.
//  2. Listo=0, two frames 6'h25 then 6'h0A -> Desborde pulse; Palabra stays 6'h25.
//     Then Listo=1 -> Valido=0.
//  3. Stop bit sent as 0 -> ErrorTrama pulses once, Valido stays 0, next good frame is received.
//  4. Macro on, PARIDAD_IMPAR=0, word 6'h07 with parity bit 0 -> ErrorTrama.
//     Same word with parity bit 1 -> Palabra=6'h07.
//  5. nReset low after the 3rd data bit -> outputs 0. Next full frame 6'h3F is received correctly.
//  6. Back-to-back frames with Listo=1 -> every word is delivered in order; no Desborde, no ErrorTrama.

Source files
------------

// File: rtl/paq_deserializador.sv
// Shared types and constants for the framed 6-bit serial deserializer.
package paq_deserializador;

   localparam int ANCHO_PALABRA = 6;
   localparam int ANCHO_CONT    = $clog2(ANCHO_PALABRA + 1);

   localparam logic LINEA_REPOSO = 1'b1;
   localparam logic BIT_INICIO   = 1'b0;

   typedef enum logic [1:0] {
      REPOSO,
      DATOS,
      PARIDAD,
      PARADA
   } estado_t;

endpackage

// File: rtl/deserializador_6bit_registro_salida.sv
// Palabra/Valido holding register with valid/ready handshake and overrun pulse.
module registro_salida_vr #(
   parameter int ANCHO = 6
) (
   input  logic             reloj,
   input  logic             rst_n,
   input  logic             entrega,
   input  logic [ANCHO-1:0] dato,
   input  logic             listo,
   output logic [ANCHO-1:0] palabra,
   output logic             valido,
   output logic             desborde
);

   always_ff @(posedge reloj or negedge rst_n) begin
      if (!rst_n) begin
         palabra  <= '0;
         valido   <= 1'b0;
         desborde <= 1'b0;
      end else begin
         desborde <= 1'b0;
         if (entrega) begin
            // A word consumed in this same cycle frees the slot for the new one.
            if (!valido || listo) begin
               palabra <= dato;
               valido  <= 1'b1;
            end else begin
               desborde <= 1'b1;
            end
         end else if (valido && listo) begin
            valido <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/deserializador_6bit.sv
// Framed serial-to-parallel receiver feeding the 6-bit comparator.
// Optional parity bit and check built when DESERIALIZADOR_PARIDAD_EN is defined.
//
// state   | meaning
// REPOSO  | line idle, waiting for a start bit on a strobe
// DATOS   | shifting in ANCHO data bits, LSB first
// PARIDAD | checking the parity bit (macro builds only)
// PARADA  | checking the stop bit, then deliver or flag ErrorTrama
module deserializador_6bit
   import paq_deserializador::*;
#(
   parameter int ANCHO = ANCHO_PALABRA
`ifdef DESERIALIZADOR_PARIDAD_EN
   ,
   parameter bit PARIDAD_IMPAR = 1'b0
`endif
) (
   input  logic             Reloj,
   input  logic             nReset,
   input  logic             DatoSerie,
   input  logic             Muestra,
   input  logic             Listo,
   output logic [ANCHO-1:0] Palabra,
   output logic             Valido,
   output logic             ErrorTrama,
   output logic             Desborde
);

   logic [1:0]            rst_sinc;
   logic                  rst_n;
   estado_t               estado;
   logic [ANCHO_CONT-1:0] contador;
   logic [ANCHO-1:0]      desplaz;
   logic                  entrega;

`ifdef DESERIALIZADOR_PARIDAD_EN
   logic error_par;
`else
   localparam logic error_par = 1'b0;
`endif

   // Reset asserts asynchronously everywhere but releases on a clock edge.
   always_ff @(posedge Reloj or negedge nReset) begin
      if (!nReset) begin
         rst_sinc <= 2'b00;
      end else begin
         rst_sinc <= {rst_sinc[0], 1'b1};
      end
   end

   assign rst_n = rst_sinc[1];

   always_comb begin
      entrega = 1'b0;
      if (Muestra && (estado == PARADA) && (DatoSerie == LINEA_REPOSO) && !error_par) begin
         entrega = 1'b1;
      end
   end

   always_ff @(posedge Reloj or negedge rst_n) begin
      if (!rst_n) begin
         estado     <= REPOSO;
         contador   <= '0;
         desplaz    <= '0;
         ErrorTrama <= 1'b0;
`ifdef DESERIALIZADOR_PARIDAD_EN
         error_par  <= 1'b0;
`endif
      end else begin
         ErrorTrama <= 1'b0;
         if (Muestra) begin
            unique case (estado)
               REPOSO: begin
                  if (DatoSerie == BIT_INICIO) begin
                     estado   <= DATOS;
                     contador <= '0;
`ifdef DESERIALIZADOR_PARIDAD_EN
                     error_par <= 1'b0;
`endif
                  end
               end
               DATOS: begin
                  desplaz  <= {DatoSerie, desplaz[ANCHO-1:1]};
                  contador <= contador + ANCHO_CONT'(1);
                  if (contador == ANCHO_CONT'(ANCHO - 1)) begin
`ifdef DESERIALIZADOR_PARIDAD_EN
                     estado <= PARIDAD;
`else
                     estado <= PARADA;
`endif
                  end
               end
               PARIDAD: begin
`ifdef DESERIALIZADOR_PARIDAD_EN
                  error_par <= (DatoSerie != ((^desplaz) ^ PARIDAD_IMPAR));
`endif
                  estado <= PARADA;
               end
               PARADA: begin
                  // Bad stop bit or recorded parity error: drop the word.
                  if (!entrega) begin
                     ErrorTrama <= 1'b1;
                  end
                  estado <= REPOSO;
               end
               default: begin
                  estado <= REPOSO;
               end
            endcase
         end
      end
   end

   registro_salida_vr #(
      .ANCHO(ANCHO)
   ) u_registro_salida (
      .reloj    (Reloj),
      .rst_n    (rst_n),
      .entrega  (entrega),
      .dato     (desplaz),
      .listo    (Listo),
      .palabra  (Palabra),
      .valido   (Valido),
      .desborde (Desborde)
   );

endmodule

// File: tb/tb_deserializador_6bit.sv
// Self-checking bench for deserializador_6bit: directed frames plus randomized traffic.
module tb_deserializador_6bit;

   logic       Reloj = 1'b0;
   logic       nReset = 1'b0;
   logic       DatoSerie = 1'b1;
   logic       Muestra = 1'b0;
   logic       Listo = 1'b0;
   logic [5:0] Palabra;
   logic       Valido;
   logic       ErrorTrama;
   logic       Desborde;

   deserializador_6bit dut (
      .Reloj      (Reloj),
      .nReset     (nReset),
      .DatoSerie  (DatoSerie),
      .Muestra    (Muestra),
      .Listo      (Listo),
      .Palabra    (Palabra),
      .Valido     (Valido),
      .ErrorTrama (ErrorTrama),
      .Desborde   (Desborde)
   );

   always #5 Reloj = ~Reloj;

   int n_checks = 0;
   int n_errores = 0;
   int modo_listo = 0;
   int n_desb = 0;
   int n_err_trama = 0;

   // Reference state: what the output register must hold after each edge.
   logic       exp_valido = 1'b0;
   logic [5:0] exp_palabra = '0;
   logic       exp_error = 1'b0;
   logic       exp_desb = 1'b0;

   logic       fin = 1'b0;
   logic       trama_ok = 1'b0;
   logic [5:0] palabra_tx = '0;
   logic [5:0] q_rx[$];
   logic [5:0] q_tx[$];

   task automatic revisar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      n_checks++;
      if (obs !== esp) begin
         n_errores++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, esp, $time);
      end
   endtask

   task automatic ciclo();
      if (modo_listo == 2) Listo = 1'($urandom_range(0, 1));
      else Listo = (modo_listo == 1);
      if (Valido && Listo) q_rx.push_back(Palabra);
      exp_error = 1'b0;
      exp_desb  = 1'b0;
      if (!nReset) begin
         exp_valido  = 1'b0;
         exp_palabra = '0;
      end else if (fin) begin
         if (!trama_ok) exp_error = 1'b1;
         else if (!exp_valido || Listo) begin
            exp_valido  = 1'b1;
            exp_palabra = palabra_tx;
         end else exp_desb = 1'b1;
      end else if (exp_valido && Listo) begin
         exp_valido = 1'b0;
      end
      @(posedge Reloj);
      #1;
      if (Desborde) n_desb++;
      if (ErrorTrama) n_err_trama++;
      revisar("valido", 32'(Valido), 32'(exp_valido));
      revisar("palabra", 32'(Palabra), 32'(exp_palabra));
      revisar("error_trama", 32'(ErrorTrama), 32'(exp_error));
      revisar("desborde", 32'(Desborde), 32'(exp_desb));
   endtask

   task automatic golpe(input logic b, input logic ultimo, input int hueco);
      DatoSerie = b;
      Muestra   = 1'b1;
      fin       = ultimo;
      ciclo();
      Muestra   = 1'b0;
      fin       = 1'b0;
      DatoSerie = 1'b1;
      repeat (hueco) ciclo();
   endtask

   // par_ok must be 1 when the parity option is not built.
   task automatic enviar(input logic [5:0] w, input logic stop, input logic par_ok, input int hueco);
      palabra_tx = w;
      trama_ok   = stop && par_ok;
      golpe(1'b0, 1'b0, hueco);
      for (int i = 0; i < 6; i++) golpe(w[i], 1'b0, hueco);
`ifdef DESERIALIZADOR_PARIDAD_EN
      golpe((^w) ^ !par_ok, 1'b0, hueco);
`endif
      golpe(stop, 1'b1, hueco);
   endtask

   initial begin
      logic [5:0] w;
      logic       stop;
      logic       pok;

      nReset = 1'b0;
      repeat (2) ciclo();
      revisar("reset_valido", 32'(Valido), 32'd0);
      revisar("reset_palabra", 32'(Palabra), 32'd0);
      nReset = 1'b1;
      repeat (4) ciclo();

      // 1: basic frame
      modo_listo = 0;
      enviar(6'h25, 1'b1, 1'b1, 1);
      revisar("t1_palabra", 32'(Palabra), 32'h25);
      revisar("t1_valido", 32'(Valido), 32'd1);

      // 2: overrun while Listo low
      n_desb = 0;
      enviar(6'h0A, 1'b1, 1'b1, 1);
      revisar("t2_desborde", 32'(n_desb), 32'd1);
      revisar("t2_palabra", 32'(Palabra), 32'h25);
      modo_listo = 1;
      ciclo();
      revisar("t2_valido", 32'(Valido), 32'd0);

      // 3: bad stop bit then good frame
      modo_listo = 0;
      n_err_trama = 0;
      enviar(6'h15, 1'b0, 1'b1, 1);
      revisar("t3_err", 32'(n_err_trama), 32'd1);
      revisar("t3_valido", 32'(Valido), 32'd0);
      enviar(6'h2A, 1'b1, 1'b1, 0);
      revisar("t3_palabra", 32'(Palabra), 32'h2A);
      revisar("t3_valido2", 32'(Valido), 32'd1);
      modo_listo = 1;
      ciclo();

`ifdef DESERIALIZADOR_PARIDAD_EN
      // 4: parity
      modo_listo = 0;
      n_err_trama = 0;
      enviar(6'h07, 1'b1, 1'b0, 1);
      revisar("t4_err", 32'(n_err_trama), 32'd1);
      revisar("t4_valido", 32'(Valido), 32'd0);
      enviar(6'h07, 1'b1, 1'b1, 1);
      revisar("t4_palabra", 32'(Palabra), 32'h07);
      modo_listo = 1;
      ciclo();
`endif

      // 5: reset mid-frame
      modo_listo = 0;
      enviar(6'h11, 1'b1, 1'b1, 0);
      revisar("t5_pre_valido", 32'(Valido), 32'd1);
      golpe(1'b0, 1'b0, 1);
      golpe(1'b1, 1'b0, 1);
      golpe(1'b0, 1'b0, 1);
      golpe(1'b1, 1'b0, 1);
      n_err_trama = 0;
      nReset = 1'b0;
      #1;
      revisar("t5_valido", 32'(Valido), 32'd0);
      revisar("t5_palabra", 32'(Palabra), 32'd0);
      repeat (3) ciclo();
      nReset = 1'b1;
      repeat (4) ciclo();
      enviar(6'h3F, 1'b1, 1'b1, 1);
      revisar("t5_err", 32'(n_err_trama), 32'd0);
      revisar("t5_palabra2", 32'(Palabra), 32'h3F);
      revisar("t5_valido2", 32'(Valido), 32'd1);

      // 6: back-to-back with Listo high, consecutive strobes
      modo_listo = 1;
      ciclo();
      q_rx.delete();
      q_tx.delete();
      n_desb = 0;
      n_err_trama = 0;
      for (int k = 0; k < 8; k++) begin
         w = 6'($urandom);
         q_tx.push_back(w);
         enviar(w, 1'b1, 1'b1, 0);
      end
      repeat (2) ciclo();
      revisar("t6_desb", 32'(n_desb), 32'd0);
      revisar("t6_err", 32'(n_err_trama), 32'd0);
      revisar("t6_cuenta", 32'(q_rx.size()), 32'd8);
      for (int k = 0; k < 8; k++) begin
         if (k < q_rx.size()) revisar("t6_orden", 32'(q_rx[k]), 32'(q_tx[k]));
      end

      // 7: randomized traffic with random Listo, gaps, idle strobes and errors
      modo_listo = 2;
      for (int k = 0; k < 40; k++) begin
         w    = 6'($urandom);
         stop = ($urandom_range(0, 7) != 0);
`ifdef DESERIALIZADOR_PARIDAD_EN
         pok  = ($urandom_range(0, 7) != 0);
`else
         pok  = 1'b1;
`endif
         enviar(w, stop, pok, $urandom_range(0, 2));
         if ($urandom_range(0, 1) == 1) golpe(1'b1, 1'b0, $urandom_range(0, 1));
      end
      repeat (4) ciclo();

      $display("Result: errors=%0d of %0d checks", n_errores, n_checks);
      $finish;
   end

endmodule
